// File: rtl/pipe_stage_reg.sv
// Pipeline register carrying PC+instruction with valid/ready, flush-to-bubble and optional 2-entry skid.
// One-cycle latency in->out; with SKID_EN=1 in_ready is a flop and drops only when both entries are held.
module pipe_stage_reg #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013),
  parameter int                SKID_EN  = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state;
  logic [PC_W-1:0]   head_pc;
  logic [INST_W-1:0] head_inst;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              rdy_q;
  logic              accept;
  logic              pop;

  assign out_valid = (state != EMPTY);
  assign out_pc    = head_pc;
  assign out_inst  = head_inst;
  // Without the skid entry the stage can only take a new word when the head leaves this cycle.
  assign in_ready  = (SKID_EN != 0) ? rdy_q : (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head_pc   <= '0;
      head_inst <= NOP_INST;
      skid_pc   <= '0;
      skid_inst <= NOP_INST;
      rdy_q     <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      head_inst <= NOP_INST;
      skid_pc   <= '0;
      skid_inst <= NOP_INST;
      rdy_q     <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            head_pc   <= in_pc;
            head_inst <= in_inst;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_pc   <= in_pc;
            head_inst <= in_inst;
          end else if (accept) begin
            // Only reachable with the skid entry enabled: in_ready is otherwise low here.
            state     <= TWO;
            skid_pc   <= in_pc;
            skid_inst <= in_inst;
            rdy_q     <= 1'b0;
          end else if (pop) begin
            state     <= EMPTY;
            head_inst <= NOP_INST;
          end
        end
        TWO: begin
          if (pop) begin
            state     <= ONE;
            head_pc   <= skid_pc;
            head_inst <= skid_inst;
            rdy_q     <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          head_inst <= NOP_INST;
          rdy_q     <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a single-entry instance side by side,
// with per-instance expected-entry queues checked by negedge monitors.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  bit mon_on = 1'b0;

  logic        s_rst, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_pc, s_in_inst, s_out_pc, s_out_inst;
  logic [3:0]  s_stall_cnt;
  logic        f_rst, f_flush, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
  logic [31:0] f_in_pc, f_in_inst, f_out_pc, f_out_inst;
  logic [15:0] f_stall_cnt;

  pipe_stage_reg #(.PC_W(32), .INST_W(32), .NOP_INST(NOP), .SKID_EN(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst(s_rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pc(s_in_pc), .in_inst(s_in_inst),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_pc(s_out_pc), .out_inst(s_out_inst),
    .stall_cnt(s_stall_cnt)
  );

  pipe_stage_reg #(.PC_W(32), .INST_W(32), .NOP_INST(NOP), .SKID_EN(0), .CNT_W(16)) u_flat (
    .clk(clk), .rst(f_rst), .flush(f_flush),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_pc(f_in_pc), .in_inst(f_in_inst),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_pc(f_out_pc), .out_inst(f_out_inst),
    .stall_cnt(f_stall_cnt)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: entries accepted and not yet delivered or flushed, oldest first.
  logic [63:0] s_q[$];
  logic [63:0] f_q[$];
  int s_cnt_m = 0;
  int f_cnt_m = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      logic rdy_m;
      check("s_out_valid", 64'(s_out_valid), 64'(s_q.size() != 0));
      check("s_in_ready", 64'(s_in_ready), 64'(s_q.size() < 2));
      if (s_q.size() != 0) check("s_head", {s_out_pc, s_out_inst}, s_q[0]);
      else check("s_nop", 64'(s_out_inst), 64'(NOP));
      check("s_stall_cnt", 64'(s_stall_cnt), 64'(s_cnt_m));
      if (s_rst) begin
        s_q.delete();
        s_cnt_m = 0;
      end else begin
        rdy_m = (s_q.size() < 2);
        if (s_q.size() != 0 && !s_out_ready && s_cnt_m != 15) s_cnt_m++;
        if (s_q.size() != 0 && s_out_ready) void'(s_q.pop_front());
        if (s_flush) s_q.delete();
        else if (s_in_valid && rdy_m) s_q.push_back({s_in_pc, s_in_inst});
      end

      check("f_out_valid", 64'(f_out_valid), 64'(f_q.size() != 0));
      check("f_in_ready", 64'(f_in_ready), 64'((f_q.size() == 0) || f_out_ready));
      if (f_q.size() != 0) check("f_head", {f_out_pc, f_out_inst}, f_q[0]);
      else check("f_nop", 64'(f_out_inst), 64'(NOP));
      check("f_stall_cnt", 64'(f_stall_cnt), 64'(f_cnt_m));
      if (f_rst) begin
        f_q.delete();
        f_cnt_m = 0;
      end else begin
        rdy_m = (f_q.size() == 0) || f_out_ready;
        if (f_q.size() != 0 && !f_out_ready && f_cnt_m != 65535) f_cnt_m++;
        if (f_q.size() != 0 && f_out_ready) void'(f_q.pop_front());
        if (f_flush) f_q.delete();
        else if (f_in_valid && rdy_m) f_q.push_back({f_in_pc, f_in_inst});
      end
    end
  end

  initial begin
    s_rst = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_pc = '0; s_in_inst = '0;
    f_rst = 1'b1; f_flush = 1'b0; f_in_valid = 1'b0; f_out_ready = 1'b0; f_in_pc = '0; f_in_inst = '0;
    tick();
    mon_on = 1'b1;
    tick();
    s_rst = 1'b0;
    f_rst = 1'b0;

    // Reset values
    check("rst_s_out_pc", 64'(s_out_pc), 64'h0);
    check("rst_s_out_inst", 64'(s_out_inst), 64'h13);
    check("rst_s_in_ready", 64'(s_in_ready), 64'h1);
    check("rst_s_stall", 64'(s_stall_cnt), 64'h0);
    check("rst_f_out_pc", 64'(f_out_pc), 64'h0);
    check("rst_f_out_valid", 64'(f_out_valid), 64'h0);

    // 1: single entry, one-cycle latency
    s_in_valid = 1'b1; s_in_pc = 32'h100; s_in_inst = 32'h00500093; s_out_ready = 1'b1;
    f_in_valid = 1'b1; f_in_pc = 32'h100; f_in_inst = 32'h00500093; f_out_ready = 1'b1;
    tick();
    s_in_valid = 1'b0; f_in_valid = 1'b0;
    check("t1_s_valid", 64'(s_out_valid), 64'h1);
    check("t1_s_pc", 64'(s_out_pc), 64'h100);
    check("t1_s_inst", 64'(s_out_inst), 64'h00500093);
    check("t1_f_valid", 64'(f_out_valid), 64'h1);
    check("t1_f_pc", 64'(f_out_pc), 64'h100);
    tick();
    check("t1_s_drained", 64'(s_out_valid), 64'h0);
    check("t1_f_drained_inst", 64'(f_out_inst), 64'h13);
    check("t1_f_pc_hold", 64'(f_out_pc), 64'h100);

    // 2: skid fills, then drains in order
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_pc = 32'h100; s_in_inst = 32'h00500093;
    tick();
    s_in_pc = 32'h104; s_in_inst = 32'h00a00113;
    tick();
    s_in_valid = 1'b0;
    check("t2_in_ready_full", 64'(s_in_ready), 64'h0);
    check("t2_head_first", 64'(s_out_pc), 64'h100);
    s_out_ready = 1'b1;
    tick();
    check("t2_head_second", 64'(s_out_pc), 64'h104);
    check("t2_inst_second", 64'(s_out_inst), 64'h00a00113);
    tick();
    check("t2_empty", 64'(s_out_valid), 64'h0);

    // 3: flush while full drops both entries and the offered input
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_pc = 32'h300; s_in_inst = 32'h22222222;
    tick();
    s_in_pc = 32'h304; s_in_inst = 32'h33333333;
    tick();
    s_flush = 1'b1; s_in_pc = 32'h200; s_in_inst = 32'h11111111;
    tick();
    s_flush = 1'b0; s_in_valid = 1'b0;
    check("t3_valid", 64'(s_out_valid), 64'h0);
    check("t3_nop", 64'(s_out_inst), 64'h13);
    check("t3_in_ready", 64'(s_in_ready), 64'h1);
    check("t3_pc_hold", 64'(s_out_pc), 64'h300);
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_no_0x200", 64'(s_out_valid), 64'h0);
    end

    // 4: back-to-back stream, no bubbles on either instance
    s_out_ready = 1'b1; f_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_in_valid = 1'b1; s_in_pc = 32'h400 + 32'(4 * i); s_in_inst = 32'h1000 + 32'(i);
      f_in_valid = 1'b1; f_in_pc = 32'h400 + 32'(4 * i); f_in_inst = 32'h2000 + 32'(i);
      tick();
      check("t4_s_valid", 64'(s_out_valid), 64'h1);
      check("t4_s_pc", 64'(s_out_pc), 64'(32'h400 + 32'(4 * i)));
      check("t4_f_valid", 64'(f_out_valid), 64'h1);
      check("t4_f_inst", 64'(f_out_inst), 64'(32'h2000 + 32'(i)));
    end
    s_in_valid = 1'b0; f_in_valid = 1'b0;
    tick();

    // 5: stall counter saturates at 15 and clears on reset
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    check("t5_cnt_cleared", 64'(s_stall_cnt), 64'h0);
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_pc = 32'h500; s_in_inst = 32'h55555555;
    tick();
    s_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("t5_cnt_sat", 64'(s_stall_cnt), 64'hf);
    tick();
    check("t5_cnt_stays", 64'(s_stall_cnt), 64'hf);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    check("t5_cnt_rst", 64'(s_stall_cnt), 64'h0);
    check("t5_valid_rst", 64'(s_out_valid), 64'h0);
    check("t5_inst_rst", 64'(s_out_inst), 64'h13);
    s_out_ready = 1'b1;

    // 6: random traffic on both instances against the scoreboards
    for (int i = 0; i < 10000; i++) begin
      s_in_valid = 1'($urandom_range(0, 1));
      s_out_ready = ($urandom_range(0, 3) != 0);
      s_flush = ($urandom_range(0, 15) == 0);
      s_in_pc = 32'h10000 + 32'(4 * i);
      s_in_inst = $urandom;
      f_in_valid = 1'($urandom_range(0, 1));
      f_out_ready = ($urandom_range(0, 3) != 0);
      f_flush = ($urandom_range(0, 15) == 0);
      f_in_pc = 32'h80000 + 32'(4 * i);
      f_in_inst = $urandom;
      tick();
    end
    s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1;
    f_in_valid = 1'b0; f_flush = 1'b0; f_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t6_s_drained", 64'(s_out_valid), 64'h0);
    check("t6_f_drained", 64'(f_out_valid), 64'h0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
